// File: rtl/cpu_top_if.sv
// Core-to-memory bus: instruction fetch index/data plus data RAM index/write/read.
// Latency: purely combinational reads; the RAM write commits on the clock edge.
// Backpressure: none; memories always answer in the same cycle.
interface cpu_top_if #(
  parameter int IAW = 12,
  parameter int DAW = 10
);
  logic [IAW-1:0] imem_idx;
  logic [31:0]    imem_dat;
  logic [DAW-1:0] dmem_idx;
  logic           dmem_we;
  logic [31:0]    dmem_wdat;
  logic [31:0]    dmem_rdat;

  modport master (
    output imem_idx, dmem_idx, dmem_we, dmem_wdat,
    input  imem_dat, dmem_rdat
  );
  modport slave_rom (
    input  imem_idx,
    output imem_dat
  );
  modport slave_ram (
    input  dmem_idx, dmem_we, dmem_wdat,
    output dmem_rdat
  );
endinterface

// File: rtl/cpu_top.sv
// Single-cycle RV32I processor: instruction ROM, data RAM, core (PC register + register file).
// Latency: one instruction retires on every non-reset rising clk edge (CPI = 1).
// Backpressure: none. Ports: clk (sole clock), rest (synchronous active-high reset).

// Instruction ROM, word-indexed, combinational read. Contents come from simulation preload.
module ins_rom #(
  parameter int DEPTH = 4096
) (
  cpu_top_if.slave_rom bus
);
  logic [31:0] rom_mem [0:DEPTH-1];

  assign bus.imem_dat = rom_mem[bus.imem_idx];
endmodule

// Data RAM, word-indexed, combinational read, write on clk edge. Never cleared by reset.
module data_ram #(
  parameter int DEPTH = 1024
) (
  input logic          clk,
  cpu_top_if.slave_ram bus
);
  logic [31:0] ram_mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (bus.dmem_we) ram_mem[bus.dmem_idx] <= bus.dmem_wdat;
  end

  assign bus.dmem_rdat = ram_mem[bus.dmem_idx];
endmodule

// Program counter register. Ports: next_pc in, pc2if_addr_o out.
module pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rest,
  input  logic [31:0] next_pc,
  output logic [31:0] pc2if_addr_o
);
  always_ff @(posedge clk) begin
    if (rest) pc2if_addr_o <= RESET_PC;
    else      pc2if_addr_o <= next_pc;
  end
endmodule

// 32 x 32 register file, two combinational read ports, one write port. x0 reads as zero.
module regs (
  input  logic        clk,
  input  logic        rest,
  input  logic [4:0]  rs1_idx,
  input  logic [4:0]  rs2_idx,
  input  logic [4:0]  rd_idx,
  input  logic        rd_we,
  input  logic [31:0] rd_dat,
  output logic [31:0] rs1_dat,
  output logic [31:0] rs2_dat
);
  logic [31:0] x_regs [0:31];

  // Reset has priority, so an instruction in flight during reset never retires.
  always_ff @(posedge clk) begin
    if (rest) begin
      for (int i = 0; i < 32; i++) x_regs[i] <= '0;
    end else if (rd_we && (rd_idx != 5'd0)) begin
      x_regs[rd_idx] <= rd_dat;
    end
  end

  assign rs1_dat = (rs1_idx == 5'd0) ? 32'd0 : x_regs[rs1_idx];
  assign rs2_dat = (rs2_idx == 5'd0) ? 32'd0 : x_regs[rs2_idx];
endmodule

// Decode, ALU, branch and next-PC logic. Drives the memory bus as master.
module cpu_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IAW      = 12,
  parameter int          DAW      = 10
) (
  input logic       clk,
  input logic       rest,
  cpu_top_if.master bus
);
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

  logic [31:0] pc, next_pc, pc_plus4, ins;
  logic [31:0] rs1_val, rs2_val, rd_dat;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] alu_b, alu_res, addr_sum;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        rd_we, br_taken, is_reg_op, store_en;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk          (clk),
    .rest         (rest),
    .next_pc      (next_pc),
    .pc2if_addr_o (pc)
  );

  regs u_regs (
    .clk     (clk),
    .rest    (rest),
    .rs1_idx (ins[19:15]),
    .rs2_idx (ins[24:20]),
    .rd_idx  (ins[11:7]),
    .rd_we   (rd_we),
    .rd_dat  (rd_dat),
    .rs1_dat (rs1_val),
    .rs2_dat (rs2_val)
  );

  assign ins       = bus.imem_dat;
  assign opcode    = ins[6:0];
  assign funct3    = ins[14:12];
  assign is_reg_op = (opcode == OP_REG);
  assign pc_plus4  = pc + 32'd4;

  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'b0};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

  // Shared adder: load/JALR use the I immediate, store uses the S immediate.
  assign addr_sum = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);

  assign bus.imem_idx  = pc[IAW+1:2];
  assign bus.dmem_idx  = addr_sum[DAW+1:2];
  assign bus.dmem_wdat = rs2_val;
  // A store aborted by reset must not reach the RAM.
  assign bus.dmem_we   = store_en & ~rest;

  assign alu_b = is_reg_op ? rs2_val : imm_i;

  // ins[30] selects SUB (register form only) and the arithmetic right shift.
  always_comb begin
    alu_res = '0;
    case (funct3)
      3'b000:  alu_res = (is_reg_op && ins[30]) ? (rs1_val - alu_b) : (rs1_val + alu_b);
      3'b001:  alu_res = rs1_val << alu_b[4:0];
      3'b010:  alu_res = {31'b0, ($signed(rs1_val) < $signed(alu_b))};
      3'b011:  alu_res = {31'b0, (rs1_val < alu_b)};
      3'b100:  alu_res = rs1_val ^ alu_b;
      3'b101:  alu_res = ins[30] ? 32'($signed(rs1_val) >>> alu_b[4:0]) : (rs1_val >> alu_b[4:0]);
      3'b110:  alu_res = rs1_val | alu_b;
      default: alu_res = rs1_val & alu_b;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_taken = (rs1_val <  rs2_val);
      3'b111:  br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  // Anything not decoded below falls through as a NOP: no writes, pc + 4.
  always_comb begin
    next_pc  = pc_plus4;
    rd_we    = 1'b0;
    rd_dat   = alu_res;
    store_en = 1'b0;
    case (opcode)
      OP_LUI:   begin rd_we = 1'b1; rd_dat = imm_u; end
      OP_AUIPC: begin rd_we = 1'b1; rd_dat = pc + imm_u; end
      OP_JAL: begin
        rd_we   = 1'b1;
        rd_dat  = pc_plus4;
        next_pc = pc + imm_j;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          rd_we   = 1'b1;
          rd_dat  = pc_plus4;
          next_pc = addr_sum & 32'hffff_fffe;
        end
      end
      OP_BRANCH: if (br_taken) next_pc = pc + imm_b;
      OP_IMM:    rd_we = 1'b1;
      OP_REG:    rd_we = 1'b1;
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          rd_we  = 1'b1;
          rd_dat = bus.dmem_rdat;
        end
      end
      OP_STORE:  store_en = (funct3 == 3'b010);
      default:   ;
    endcase
  end
endmodule

module cpu_top #(
  parameter int          ROM_DEPTH = 4096,
  parameter int          RAM_DEPTH = 1024,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input logic clk,
  input logic rest
);
  localparam int IAW = $clog2(ROM_DEPTH);
  localparam int DAW = $clog2(RAM_DEPTH);

  cpu_top_if #(.IAW(IAW), .DAW(DAW)) bus ();

  ins_rom #(.DEPTH(ROM_DEPTH)) u_ins_rom (
    .bus (bus.slave_rom)
  );

  data_ram #(.DEPTH(RAM_DEPTH)) u_data_ram (
    .clk (clk),
    .bus (bus.slave_ram)
  );

  cpu_core #(.RESET_PC(RESET_PC), .IAW(IAW), .DAW(DAW)) u_cpu_core (
    .clk  (clk),
    .rest (rest),
    .bus  (bus.master)
  );
endmodule

// File: tb/tb_cpu_top.sv
// Bench for cpu_top: directed programs with literal expectations, then random programs
// checked every cycle against an instruction-level model of RV32I held in the bench.
// Stimulus: preloaded ROM/RAM images, single-cycle and random mid-program resets.
module tb_cpu_top;
  logic clk;
  logic rest;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Instruction-level model state.
  logic [31:0] m_rom [0:4095];
  logic [31:0] m_ram [0:1023];
  logic [31:0] m_x   [0:31];
  logic [31:0] m_pc;

  cpu_top dut (
    .clk  (clk),
    .rest (rest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
    logic [31:0] im;
    im = imm;
    return {im[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
  endfunction

  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
    logic [31:0] im;
    im = imm;
    return {im[11:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    logic [31:0] im;
    im = imm;
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_u(int imm20, int rd, int op);
    return {20'(imm20), 5'(rd), 7'(op)};
  endfunction

  function automatic logic [31:0] enc_j(int imm, int rd);
    logic [31:0] im;
    im = imm;
    return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'h6f};
  endfunction

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
  endtask

  function automatic logic [31:0] model_alu(int f3, bit alt, bit is_reg, logic [31:0] a, logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (f3)
      0: return (is_reg && alt) ? a - b : a + b;
      1: return a << sh;
      2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3: return (a < b) ? 32'd1 : 32'd0;
      4: return a ^ b;
      5: return alt ? 32'($signed(a) >>> sh) : a >> sh;
      6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] ins, a, b, val, nxt, addr, imm_i, imm_s, imm_b, imm_j;
    logic [11:0] ridx;
    int op, f3, rd;
    bit wr, taken;
    ridx  = m_pc[13:2];
    ins   = m_rom[ridx];
    op    = int'(ins[6:0]);
    f3    = int'(ins[14:12]);
    rd    = int'(ins[11:7]);
    a     = m_x[ins[19:15]];
    b     = m_x[ins[24:20]];
    imm_i = 32'($signed(ins) >>> 20);
    imm_s = (32'($signed(ins) >>> 25) << 5) | 32'(ins[11:7]);
    imm_b = (32'($signed(ins) >>> 31) << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
    imm_j = (32'($signed(ins) >>> 31) << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
    nxt = m_pc + 4;
    wr  = 1'b0;
    val = 32'd0;
    case (op)
      'h37: begin wr = 1'b1; val = ins & 32'hffff_f000; end
      'h17: begin wr = 1'b1; val = m_pc + (ins & 32'hffff_f000); end
      'h6f: begin wr = 1'b1; val = m_pc + 4; nxt = m_pc + imm_j; end
      'h67: if (f3 == 0) begin wr = 1'b1; val = m_pc + 4; nxt = (a + imm_i) & ~32'd1; end
      'h63: begin
        case (f3)
          0: taken = (a == b);
          1: taken = (a != b);
          4: taken = ($signed(a) <  $signed(b));
          5: taken = ($signed(a) >= $signed(b));
          6: taken = (a <  b);
          7: taken = (a >= b);
          default: taken = 1'b0;
        endcase
        if (taken) nxt = m_pc + imm_b;
      end
      'h13: begin wr = 1'b1; val = model_alu(f3, ins[30], 1'b0, a, imm_i); end
      'h33: begin wr = 1'b1; val = model_alu(f3, ins[30], 1'b1, a, b); end
      'h03: if (f3 == 2) begin addr = a + imm_i; wr = 1'b1; val = m_ram[addr[11:2]]; end
      'h23: if (f3 == 2) begin addr = a + imm_s; m_ram[addr[11:2]] = b; end
      default: ;
    endcase
    if (wr && rd != 0) m_x[rd] = val;
    m_pc = nxt;
  endtask

  always @(posedge clk) begin
    if (rest) model_reset();
    else if (cmp_en) model_step();
  end

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_pc();
    return dut.u_cpu_core.u_pc_reg.pc2if_addr_o;
  endfunction

  function automatic logic [31:0] rx(int i);
    return dut.u_cpu_core.u_regs.x_regs[i];
  endfunction

  // Per-cycle comparison of architectural state against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      int bad;
      check("pc_vs_model", dut_pc(), m_pc);
      bad = -1;
      for (int i = 0; i < 32; i++)
        if (bad < 0 && rx(i) !== m_x[i]) bad = i;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL regs_vs_model x%0d: got %08h expected %08h (pc %08h)", bad, rx(bad), m_x[bad], m_pc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic put(int idx, logic [31:0] w);
    dut.u_ins_rom.rom_mem[idx] = w;
    m_rom[idx] = w;
  endtask

  task automatic fill_rom_nop();
    for (int i = 0; i < 4096; i++) put(i, 32'h0000_0013);
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 1024; i++) begin
      dut.u_data_ram.ram_mem[i] = 32'd0;
      m_ram[i] = 32'd0;
    end
  endtask

  // Caller has set rest = 1 and loaded images; release after one reset edge.
  task automatic release_reset();
    @(posedge clk);
    @(negedge clk);
    rest = 1'b0;
    cmp_en = 1'b1;
  endtask

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_ins();
    int k, rd, rs1, rs2, f3;
    int f3tab[6] = '{0, 1, 4, 5, 6, 7};
    k   = $urandom_range(0, 29);
    rd  = $urandom_range(0, 15);
    rs1 = $urandom_range(0, 15);
    rs2 = $urandom_range(0, 15);
    f3  = $urandom_range(0, 7);
    if (k == 0)  return enc_u($urandom, rd, 'h37);
    if (k == 1)  return enc_u($urandom, rd, 'h17);
    if (k == 2)  return enc_j(($urandom_range(0, 63) - 32) * 4, rd);
    if (k == 3)  return enc_i($urandom_range(0, 4095), rs1, 0, rd, 'h67);
    if (k <= 9)  return enc_b(($urandom_range(0, 63) - 32) * 4, rs2, rs1, f3tab[k - 4]);
    if (k <= 15) begin
      if (f3 == 1) return enc_i($urandom_range(0, 31), rs1, 1, rd, 'h13);
      if (f3 == 5) return enc_i(($urandom_range(0, 1) * 'h400) + $urandom_range(0, 31), rs1, 5, rd, 'h13);
      return enc_i($urandom_range(0, 4095), rs1, f3, rd, 'h13);
    end
    if (k <= 22) return enc_r(((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 'h20 : 0, rs2, rs1, f3, rd);
    if (k <= 25) return enc_i($urandom_range(0, 4095), rs1, 2, rd, 'h03);
    if (k <= 28) return enc_s($urandom_range(0, 4095), rs2, rs1, 2);
    case ($urandom_range(0, 3))
      0: return 32'h0000_000f;
      1: return 32'h0000_0073;
      2: return enc_i($urandom_range(0, 4095), rs1, 0, rd, 'h03);
      default: return enc_s($urandom_range(0, 4095), rs2, rs1, 0);
    endcase
  endfunction

  task automatic load_p1();
    fill_rom_nop();
    put(0, enc_i(5, 0, 0, 1, 'h13));    // ADDI x1,x0,5
    put(1, enc_i(-2, 1, 0, 3, 'h13));   // ADDI x3,x1,-2
    put(2, enc_r(0, 3, 1, 0, 4));       // ADD  x4,x1,x3
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rest = 1'b1;

    // Arithmetic chain, and reset state.
    load_p1();
    clear_ram();
    release_reset();
    check("reset_pc", dut_pc(), 32'd0);
    check("reset_x1", rx(1), 32'd0);
    cycles(3);
    check("p1_pc", dut_pc(), 32'd12);
    check("p1_x1", rx(1), 32'd5);
    check("p1_x3", rx(3), 32'd3);
    check("p1_x4", rx(4), 32'd8);

    // LUI/ADDI build a constant, SW then LW round-trips it through RAM.
    @(negedge clk); rest = 1'b1;
    fill_rom_nop();
    put(0, enc_u('h12345, 5, 'h37));
    put(1, enc_i('h678, 5, 0, 5, 'h13));
    put(2, enc_s(8, 5, 0, 2));
    put(3, enc_i(8, 0, 2, 6, 'h03));
    release_reset();
    cycles(4);
    check("p2_x5", rx(5), 32'h1234_5678);
    check("p2_x6", rx(6), 32'h1234_5678);
    check("p2_pc", dut_pc(), 32'd16);

    // Taken BEQ, then not-taken BNE.
    @(negedge clk); rest = 1'b1;
    fill_rom_nop();
    put(0, enc_i(1, 0, 0, 1, 'h13));
    put(1, enc_b(8, 1, 1, 0));
    put(3, enc_b(8, 1, 1, 1));
    release_reset();
    cycles(2);
    check("beq_taken_pc", dut_pc(), 32'd12);
    cycles(1);
    check("bne_not_taken_pc", dut_pc(), 32'd16);

    // JAL then JALR back through the link register.
    @(negedge clk); rest = 1'b1;
    fill_rom_nop();
    put(0, enc_j(16, 7));
    put(4, enc_i(0, 7, 0, 1, 'h67));
    release_reset();
    cycles(1);
    check("jal_x7", rx(7), 32'd4);
    check("jal_pc", dut_pc(), 32'd16);
    cycles(1);
    check("jalr_pc", dut_pc(), 32'd4);
    check("jalr_x1", rx(1), 32'd20);

    // x0 hardwired; signed vs unsigned compare.
    @(negedge clk); rest = 1'b1;
    fill_rom_nop();
    put(0, enc_i(7, 0, 0, 0, 'h13));
    put(1, enc_r(0, 0, 0, 0, 3));
    put(2, enc_i(-1, 0, 0, 1, 'h13));
    put(3, enc_i(1, 0, 0, 2, 'h13));
    put(4, enc_r(0, 2, 1, 2, 8));
    put(5, enc_r(0, 2, 1, 3, 9));
    release_reset();
    cycles(6);
    check("x0_zero", rx(0), 32'd0);
    check("add_x0_x3", rx(3), 32'd0);
    check("slt_x8", rx(8), 32'd1);
    check("sltu_x9", rx(9), 32'd0);

    // Single-cycle reset mid-program restarts from word 0.
    @(negedge clk); rest = 1'b1;
    load_p1();
    release_reset();
    cycles(2);
    rest = 1'b1;
    @(negedge clk);
    rest = 1'b0;
    check("midrst_pc", dut_pc(), 32'd0);
    check("midrst_x1", rx(1), 32'd0);
    check("midrst_x3", rx(3), 32'd0);
    cycles(3);
    check("restart_pc", dut_pc(), 32'd12);
    check("restart_x4", rx(4), 32'd8);

    // Random programs over the whole ROM, with occasional resets.
    for (int round = 0; round < 3; round++) begin
      if (errors > 30) break;
      @(negedge clk); rest = 1'b1;
      for (int i = 0; i < 4096; i++) put(i, rnd_ins());
      clear_ram();
      release_reset();
      for (int c = 0; c < 1500; c++) begin
        if (errors > 30) break;
        rest = ($urandom_range(0, 299) == 0);
        @(negedge clk);
      end
      rest = 1'b0;
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_top.md
Name: cpu_top

Overview:
- Minimal single-cycle RV32I processor top. Contains the instruction ROM `u_ins_rom`, data RAM `u_data_ram` and core `u_cpu_core`.
- The core contains the PC register `u_pc_reg` and register file `u_regs`.
- The simulation bench preloads the instruction image and probes internal state by hierarchical path, so these instance and array names are part of the interface:
  - `u_ins_rom.rom_mem`
  - `u_cpu_core.u_pc_reg.pc2if_addr_o`
  - `u_cpu_core.u_regs.x_regs[0..31]`

Parameters:
- ROM_DEPTH, 4096, instruction ROM words (32-bit), word-addressed.
- RAM_DEPTH, 1024, data RAM words (32-bit), word-addressed.
- RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rest  input  1  reset; one clock, reset is synchronous and active-high.

Behaviour:
- Reset (rest=1 at a rising clk):
  - pc2if_addr_o <= RESET_PC.
  - All x_regs <= 0.
  - RAM contents are not cleared.
  - Reset asserted mid-program aborts the current instruction; nothing retires that cycle.
- Fetch:
  - instr = rom_mem[pc[log2(ROM_DEPTH)+1:2]], read combinationally.
  - Low PC bits are ignored.
  - The index truncates, so out-of-range PCs wrap.
- Single-cycle execution: each non-reset rising edge retires exactly one instruction (register/RAM write plus PC update). CPI = 1.
- x0 is hardwired to 0. Writes to rd=0 are discarded, and reads of x0 return 0.
- Register reads are combinational. The write occurs at the clock edge, so a result is visible to the next instruction.
- Supported instructions:
  - LUI, AUIPC.
  - JAL, JALR: rd <= pc+4. JALR target = (rs1+imm) & ~1.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU: taken -> pc+imm_B, else pc+4.
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
  - LW, SW: address = rs1+imm; RAM index = addr[log2(RAM_DEPTH)+1:2]; wraps.
  - LW: rd <= ram[idx] (combinational read).
  - SW: ram[idx] <= rs2 at the clock edge.
- Arithmetic and immediates:
  - All arithmetic is 32-bit modulo 2^32.
  - Immediates are sign-extended per the RV32I I/S/B/U/J formats.
  - Shift amount = low 5 bits.
  - SLT/BLT/BGE are signed compares; *U variants are unsigned.
- Unsupported opcodes (including FENCE, ECALL, byte/half loads/stores) execute as NOP: no writes, pc <= pc+4.
- There are no exceptions, interrupts or misalignment traps.
- Initial state before the first reset is undefined. The ROM is loaded only by simulation preload (binary text, one 32-bit word per line).

Test Plan:
- Reset, then ADDI x1,x0,5; ADDI x3,x1,-2; ADD x4,x1,x3 -> after 3 cycles PC=12, x1=5, x3=3, x4=8.
- LUI x5,0x12345; ADDI x5,x5,0x678; SW x5,8(x0); LW x6,8(x0) -> x5=x6=0x12345678.
- ADDI x1,x0,1; BEQ x1,x1,+8 (at PC=4) -> next PC=12. BNE x1,x1 -> PC+4.
- JAL x7,+16 at PC=0 -> x7=4, PC=16. JALR x1,0(x7) -> PC=4, x1=20.
- ADDI x0,x0,7 then ADD x3,x0,x0 -> x0 stays 0, x3=0. SLT/SLTU with x1=-1, x2=1 -> SLT=1, SLTU=0.
- Assert rest for one cycle mid-program -> PC=0 and x1..x31=0 on the next edge; execution restarts from word 0.
